// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encodings and divider iteration constants.
package mdu_hilo_pkg;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_div.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// cycle. The quotient register doubles as the dividend shift register.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              load operands and begin (ignored while abort)
//   abort              drop any in-flight division
//   dividend, divisor  unsigned magnitudes
//   done               high during the cycle the last step executes;
//                      quotient/remainder are final after that edge
//   quotient, remainder
module mdu_div
    import mdu_hilo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    logic                  busy;
    logic [DIV_CNT_W-1:0]  cnt;
    logic [DATA_WIDTH-1:0] dvsr;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   diff;

    always_comb begin
        rem_sh = {remainder, quotient[DATA_WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr};
    end

    assign done = busy & (cnt == DIV_CNT_W'(DIV_ITERS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            dvsr      <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            // counter wraps back to 0 on the final step
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
            if (!diff[DATA_WIDTH]) begin
                remainder <= diff[DATA_WIDTH-1:0];
                quotient  <= {quotient[DATA_WIDTH-2:0], 1'b1};
            end else begin
                remainder <= rem_sh[DATA_WIDTH-1:0];
                quotient  <= {quotient[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the HI/LO registers. One op at a time.
// Ports:
//   clk, rst                synchronous active-high reset
//   flush                   abort in-flight op, drop same-cycle accept
//   in_valid, mdu_op        op issue
//   src1, src2              rs / rt operands
//   mdu_ready               unit idle (state == IDLE)
//   mdu_res, mdu_res_byte_wen  MFHI/MFLO result and byte enables
//   hi_out, lo_out          current HI/LO
//
// state | meaning
// IDLE  | accepting ops; MFxx/MTxx complete here
// MUL   | multiply in progress, MUL_LAT cycles, writes HI/LO on last
// DIV   | divider stepping, 32 cycles
// FIX   | apply quotient/remainder signs, write HI/LO
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [2:0]            mdu_op,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    output logic                  mdu_ready,
    output logic [DATA_WIDTH-1:0] mdu_res,
    output logic [3:0]            mdu_res_byte_wen,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    mdu_state_e state, state_next;
    mdu_op_e    op;

    logic                    accept, div_start, mul_wr, fix_wr;
    logic [DATA_WIDTH-1:0]   hi, lo;
    logic [DATA_WIDTH-1:0]   op_a, op_b;
    logic                    mul_signed;
    logic [MCW-1:0]          mul_cnt;
    logic [2*DATA_WIDTH-1:0] ext_a, ext_b, prod;
    logic                    q_neg, r_neg, dbz;
    logic                    a_neg, b_neg;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic                    div_done;
    logic [DATA_WIDTH-1:0]   quo, rem, fix_lo, fix_hi;

    assign op        = mdu_op_e'(mdu_op);
    assign mdu_ready = (state == ST_IDLE);
    assign hi_out    = hi;
    assign lo_out    = lo;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = in_valid & (state == ST_IDLE) & ~flush;
        div_start  = 1'b0;
        mul_wr     = 1'b0;
        fix_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MULT || op == OP_MULTU)
                        state_next = ST_MUL;
                    else if (op == OP_DIV || op == OP_DIVU) begin
                        state_next = ST_DIV;
                        div_start  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_cnt == '0) begin
                    state_next = ST_IDLE;
                    mul_wr     = ~flush;
                end
            end
            ST_DIV: begin
                if (div_done)
                    state_next = ST_FIX;
            end
            ST_FIX: begin
                state_next = ST_IDLE;
                fix_wr     = ~flush;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush)
            state_next = ST_IDLE;
    end

    // Sign-extending both operands to 64 bits makes the truncated
    // 64-bit product correct for both signed and unsigned multiply.
    always_comb begin
        ext_a = {{DATA_WIDTH{mul_signed & op_a[DATA_WIDTH-1]}}, op_a};
        ext_b = {{DATA_WIDTH{mul_signed & op_b[DATA_WIDTH-1]}}, op_b};
        prod  = ext_a * ext_b;
    end

    always_comb begin
        a_neg = (op == OP_DIV) & src1[DATA_WIDTH-1];
        b_neg = (op == OP_DIV) & src2[DATA_WIDTH-1];
        mag_a = a_neg ? -src1 : src1;
        mag_b = b_neg ? -src2 : src2;
    end

    // Divide by zero bypasses the sign fix-up: LO=all ones, HI=raw dividend.
    always_comb begin
        fix_lo = dbz ? '1 : (q_neg ? -quo : quo);
        fix_hi = dbz ? op_a : (r_neg ? -rem : rem);
    end

    mdu_div #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi               <= '0;
            lo               <= '0;
            mdu_res          <= '0;
            mdu_res_byte_wen <= '0;
            op_a             <= '0;
            op_b             <= '0;
            mul_signed       <= 1'b0;
            mul_cnt          <= '0;
            q_neg            <= 1'b0;
            r_neg            <= 1'b0;
            dbz              <= 1'b0;
        end else begin
            if (flush)
                mdu_res_byte_wen <= '0;
            if (accept) begin
                mdu_res_byte_wen <= '0;
                op_a             <= src1;
                op_b             <= src2;
                mul_signed       <= (op == OP_MULT);
                mul_cnt          <= MCW'(MUL_LAT - 1);
                q_neg            <= a_neg ^ b_neg;
                r_neg            <= a_neg;
                dbz              <= (src2 == '0);
                case (op)
                    OP_MFHI: begin
                        mdu_res          <= hi;
                        mdu_res_byte_wen <= 4'b1111;
                    end
                    OP_MFLO: begin
                        mdu_res          <= lo;
                        mdu_res_byte_wen <= 4'b1111;
                    end
                    OP_MTHI: hi <= src1;
                    OP_MTLO: lo <= src1;
                    default: ;
                endcase
            end else if (state == ST_MUL && mul_cnt != '0) begin
                mul_cnt <= mul_cnt - 1'b1;
            end
            if (mul_wr) begin
                hi <= prod[2*DATA_WIDTH-1:DATA_WIDTH];
                lo <= prod[DATA_WIDTH-1:0];
            end
            if (fix_wr) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: a cycle-level reference model built on
// plain arithmetic (*, /, %) checked every cycle, plus directed literal checks.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid;
    logic [2:0]  mdu_op;
    logic [31:0] src1, src2;
    logic        mdu_ready;
    logic [31:0] mdu_res, hi_out, lo_out;
    logic [3:0]  mdu_res_byte_wen;

    int checks = 0;
    int errors = 0;

    mdu_hilo #(.DATA_WIDTH(32), .MUL_LAT(MUL_LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .mdu_op           (mdu_op),
        .src1             (src1),
        .src2             (src2),
        .mdu_ready        (mdu_ready),
        .mdu_res          (mdu_res),
        .mdu_res_byte_wen (mdu_res_byte_wen),
        .hi_out           (hi_out),
        .lo_out           (lo_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_busy;
    logic [31:0] m_hi, m_lo, m_res, p_hi, p_lo;
    logic [3:0]  m_wen;

    function automatic logic [63:0] f_mul(logic [31:0] a, logic [31:0] b, bit sgn);
        longint x, y, p;
        x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        p = x * y;
        return 64'(p);
    endfunction

    // returns {hi, lo}
    function automatic logic [63:0] f_div(logic [31:0] a, logic [31:0] b, bit sgn);
        longint x, y, q, r;
        logic [63:0] qv, rv;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        q = x / y;
        r = x % y;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0;
            m_hi <= '0; m_lo <= '0; m_res <= '0; m_wen <= '0;
            p_hi <= '0; p_lo <= '0;
        end else if (flush) begin
            m_busy <= 0;
            m_wen  <= '0;
        end else if (m_busy != 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (in_valid) begin
            m_wen <= '0;
            case (mdu_op)
                3'd0, 3'd1: begin
                    {p_hi, p_lo} <= f_mul(src1, src2, mdu_op == 3'd0);
                    m_busy <= MUL_LAT;
                end
                3'd2, 3'd3: begin
                    {p_hi, p_lo} <= f_div(src1, src2, mdu_op == 3'd2);
                    m_busy <= DIV_LAT;
                end
                3'd4: begin m_res <= m_hi; m_wen <= 4'hF; end
                3'd5: begin m_res <= m_lo; m_wen <= 4'hF; end
                3'd6: m_hi <= src1;
                default: m_lo <= src1;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_ready", 32'(mdu_ready), 32'(m_busy == 0));
            check("cyc_hi", hi_out, m_hi);
            check("cyc_lo", lo_out, m_lo);
            check("cyc_wen", 32'(mdu_res_byte_wen), 32'(m_wen));
            if (m_wen != 0)
                check("cyc_res", mdu_res, m_res);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        mdu_op   = op;
        src1     = a;
        src2     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!mdu_ready && n < 100) begin
            n++;
            tick();
        end
        if (!mdu_ready) check("ready_timeout", 32'(mdu_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        mdu_op = 3'd0; src1 = '0; src2 = '0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_ready", 32'(mdu_ready), 32'd1);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        check("rst_res", mdu_res, 32'h0);
        check("rst_wen", 32'(mdu_res_byte_wen), 32'h0);

        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        issue(OP_MFHI, 32'h0, 32'h0);
        check("mfhi_res", mdu_res, 32'h1234_5678);
        check("mfhi_wen", 32'(mdu_res_byte_wen), 32'hF);
        check("mfhi_ready", 32'(mdu_ready), 32'd1);

        issue(OP_MULT, 32'hFFFF_FFFF, 32'h2);
        wait_ready(n);
        check("mult_lat", 32'(n), 32'(MUL_LAT));
        check("mult_hi", hi_out, 32'hFFFF_FFFF);
        check("mult_lo", lo_out, 32'hFFFF_FFFE);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_ready(n);
        check("multu_lat", 32'(n), 32'(MUL_LAT));
        check("multu_hi", hi_out, 32'h1);
        check("multu_lo", lo_out, 32'hFFFF_FFFE);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        wait_ready(n);
        check("div_lat", 32'(n), 32'd33);
        check("div_lo", lo_out, 32'hFFFF_FFFD);
        check("div_hi", hi_out, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'h7, 32'h2);
        wait_ready(n);
        check("divu_lat", 32'(n), 32'd33);
        check("divu_lo", lo_out, 32'h3);
        check("divu_hi", hi_out, 32'h1);
        issue(OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9);   // 100 / -7
        wait_ready(n);
        check("divneg_lo", lo_out, 32'hFFFF_FFF2);
        check("divneg_hi", hi_out, 32'h2);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(n);
        check("ovf_lo", lo_out, 32'h8000_0000);
        check("ovf_hi", hi_out, 32'h0);
        issue(OP_DIVU, 32'h5, 32'h0);
        wait_ready(n);
        check("dbz_lat", 32'(n), 32'd33);
        check("dbz_lo", lo_out, 32'hFFFF_FFFF);
        check("dbz_hi", hi_out, 32'h5);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0);
        wait_ready(n);
        check("sdbz_lo", lo_out, 32'hFFFF_FFFF);
        check("sdbz_hi", hi_out, 32'hFFFF_FFF9);

        // flush in cycle 10 of a divide
        issue(OP_MTHI, 32'h0000_AAAA, 32'h0);
        issue(OP_MTLO, 32'h0000_5555, 32'h0);
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", 32'(mdu_ready), 32'd1);
        check("flush_hi", hi_out, 32'h0000_AAAA);
        check("flush_lo", lo_out, 32'h0000_5555);
        issue(OP_MFLO, 32'h0, 32'h0);
        check("flush_mflo", mdu_res, 32'h0000_5555);

        // flush on the final multiply cycle suppresses the write
        issue(OP_MULT, 32'd3, 32'd4);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("mflush_hi", hi_out, 32'h0000_AAAA);
        check("mflush_lo", lo_out, 32'h0000_5555);
        check("mflush_wen", 32'(mdu_res_byte_wen), 32'h0);

        // flush drops a same-cycle accept
        flush = 1'b1;
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        flush = 1'b0;
        check("flushacc_hi", hi_out, 32'h0000_AAAA);

        // MFHI while divider busy is ignored
        issue(OP_DIVU, 32'd10, 32'd3);
        tick();
        issue(OP_MFHI, 32'h0, 32'h0);
        check("busy_mfhi_wen", 32'(mdu_res_byte_wen), 32'h0);
        wait_ready(n);
        check("busy_mfhi_wen2", 32'(mdu_res_byte_wen), 32'h0);
        issue(OP_MFHI, 32'h0, 32'h0);
        check("reissue_res", mdu_res, 32'h1);
        check("reissue_wen", 32'(mdu_res_byte_wen), 32'hF);

        // reset mid-operation
        issue(OP_DIVU, 32'd99, 32'd5);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(mdu_ready), 32'd1);
        check("midrst_hi", hi_out, 32'h0);
        check("midrst_lo", lo_out, 32'h0);
        check("midrst_wen", 32'(mdu_res_byte_wen), 32'h0);
        repeat (40) tick();
        check("midrst_idle", 32'(mdu_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
